// File: rtl/cnt_uart_tx_if.sv
// Byte handshake between the counter (producer) and the UART transmitter.
interface cnt_uart_tx_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready;

  modport master (output data_in, output valid_in, input ready);
  modport slave  (input data_in, input valid_in, output ready);
endinterface

// File: rtl/cnt_uart_tx.sv
// 8N1 UART transmitter for the counter value; optionally renders it as
// two uppercase hex chars plus CR LF so a terminal shows one count per line.
module cnt_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter bit ASCII_MODE   = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  cnt_uart_tx_if.slave  bus,
  output logic          tx,
  output logic          busy
);
  localparam int         BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [1:0] LAST_CHAR = ASCII_MODE ? 2'd3 : 2'd0;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_baud,  w_baud_nxt;
  logic [2:0]    r_bit,   w_bit_nxt;
  logic [1:0]    r_char,  w_char_nxt;
  logic [7:0]    r_data,  w_data_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx,    w_tx_nxt;
  logic          r_ready, w_ready_nxt;
  logic          w_accept, w_baud_tc;

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] char_sel(input logic [1:0] idx, input logic [7:0] d);
    logic [7:0] c;
    c = d;
    if (ASCII_MODE) begin
      case (idx)
        2'd0:    c = hex(d[7:4]);
        2'd1:    c = hex(d[3:0]);
        2'd2:    c = 8'h0D;
        default: c = 8'h0A;
      endcase
    end
    return c;
  endfunction

  assign w_accept  = bus.valid_in & r_ready;
  assign w_baud_tc = (r_baud == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BW'(1);
    w_bit_nxt   = r_bit;
    w_char_nxt  = r_char;
    w_data_nxt  = r_data;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_ready_nxt = r_ready;
    case (r_state)
      IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        if (w_accept) begin
          // First char comes straight from the bus; the latch isn't visible yet.
          w_data_nxt  = bus.data_in;
          w_shift_nxt = char_sel(2'd0, bus.data_in);
          w_char_nxt  = 2'd0;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = 1'b0;
          w_ready_nxt = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_baud_tc) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_tx_nxt    = r_shift[0];
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_baud_tc) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_tx_nxt    = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_baud_tc) begin
          w_baud_nxt = '0;
          if (r_char == LAST_CHAR) begin
            w_tx_nxt    = 1'b1;
            w_ready_nxt = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_char_nxt  = r_char + 2'd1;
            w_shift_nxt = char_sel(r_char + 2'd1, r_data);
            w_tx_nxt    = 1'b0;
            w_state_nxt = START;
          end
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_ready_nxt = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_char  <= '0;
      r_data  <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_char  <= w_char_nxt;
      r_data  <= w_data_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  assign bus.ready = r_ready;
  assign tx        = r_tx;
  assign busy      = ~r_ready;
endmodule

// File: tb/tb_cnt_uart_tx.sv
// Directed bench for cnt_uart_tx: a raw-mode and an ASCII-mode instance,
// per-line UART decoders feeding a scoreboard of expected characters.
module tb_cnt_uart_tx;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic tx_raw, busy_raw, tx_asc, busy_asc;
  int   tests = 0;
  int   errs  = 0;
  logic [1:0] mon_en = 2'b11;
  logic [7:0] exp_raw[$];
  logic [7:0] exp_asc[$];

  cnt_uart_tx_if if_raw ();
  cnt_uart_tx_if if_asc ();

  cnt_uart_tx #(.CLKS_PER_BIT(C), .ASCII_MODE(1'b0)) u_raw (
    .clk(clk), .rst_n(rst_n), .bus(if_raw.slave), .tx(tx_raw), .busy(busy_raw));
  cnt_uart_tx #(.CLKS_PER_BIT(C), .ASCII_MODE(1'b1)) u_asc (
    .clk(clk), .rst_n(rst_n), .bus(if_asc.slave), .tx(tx_asc), .busy(busy_asc));

  always #5 clk = ~clk;

  function automatic logic txv(input bit w);
    return w ? tx_asc : tx_raw;
  endfunction
  function automatic logic rdy(input bit w);
    return w ? if_asc.ready : if_raw.ready;
  endfunction
  function automatic logic bsy(input bit w);
    return w ? busy_asc : busy_raw;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic push_msg(input bit w, input logic [7:0] d);
    if (!w) exp_raw.push_back(d);
    else begin
      exp_asc.push_back(hexc(d[7:4]));
      exp_asc.push_back(hexc(d[3:0]));
      exp_asc.push_back(8'h0D);
      exp_asc.push_back(8'h0A);
    end
  endtask

  // UART decoder: sampled on negedges, mid-bit.
  task automatic monitor(input bit w);
    logic [7:0] b;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (mon_en[w] && txv(w) === 1'b0) begin
        repeat (C/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clk);
          b[i] = txv(w);
        end
        repeat (C) @(negedge clk);
        chk(w ? "asc_stop_bit" : "raw_stop_bit", {63'd0, txv(w)}, 64'd1);
        if (w) e = (exp_asc.size() > 0) ? {1'b0, exp_asc.pop_front()} : 9'h100;
        else   e = (exp_raw.size() > 0) ? {1'b0, exp_raw.pop_front()} : 9'h100;
        chk(w ? "asc_char" : "raw_char", {55'd0, 1'b0, b}, {55'd0, e});
      end
    end
  endtask

  initial monitor(1'b0);
  initial monitor(1'b1);

  task automatic drive(input bit w, input logic [7:0] d, input logic v);
    if (w) begin if_asc.data_in = d; if_asc.valid_in = v; end
    else   begin if_raw.data_in = d; if_raw.valid_in = v; end
  endtask

  // Pulse valid for one edge; returns at the first negedge after the accept.
  task automatic send(input bit w, input logic [7:0] d);
    drive(w, d, 1'b1);
    @(negedge clk);
    drive(w, d, 1'b0);
  endtask

  task automatic wait_ready(input bit w, input string tag);
    int n = 0;
    while (rdy(w) !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {63'd0, rdy(w)}, 64'd1);
  endtask

  initial begin
    logic [39:0] wave, ewave;
    logic [9:0]  frame;
    int lows, zeros;

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_tx_raw",   {63'd0, tx_raw},       64'd1);
    chk("rst_ready_raw",{63'd0, if_raw.ready}, 64'd1);
    chk("rst_busy_raw", {63'd0, busy_raw},     64'd0);
    chk("rst_tx_asc",   {63'd0, tx_asc},       64'd1);

    // valid held during reset must not be accepted
    drive(1'b0, 8'h3C, 1'b1);
    repeat (3) @(negedge clk);
    chk("rstv_ready", {63'd0, if_raw.ready}, 64'd1);
    chk("rstv_busy",  {63'd0, busy_raw},     64'd0);
    chk("rstv_tx",    {63'd0, tx_raw},       64'd1);
    push_msg(1'b0, 8'h3C);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_accept_busy", {63'd0, busy_raw}, 64'd1);
    chk("first_accept_tx",   {63'd0, tx_raw},   64'd0);
    drive(1'b0, 8'h3C, 1'b0);
    wait_ready(1'b0, "raw_3c_done");
    repeat (3) @(negedge clk);

    // raw 0xA5: full waveform and ready-low length
    push_msg(1'b0, 8'hA5);
    send(1'b0, 8'hA5);
    drive(1'b0, 8'h00, 1'b0);
    frame = {1'b1, 8'hA5, 1'b0};
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      wave[i]  = tx_raw;
      ewave[i] = frame[i/C];
      if (if_raw.ready === 1'b0) lows++;
      @(negedge clk);
    end
    chk("raw_a5_wave",      {24'd0, wave}, {24'd0, ewave});
    chk("raw_a5_ready_low", 64'(lows), 64'd40);
    chk("raw_a5_ready_back",{63'd0, if_raw.ready}, 64'd1);
    repeat (2) @(negedge clk);

    // reset in the middle of data bit 3
    mon_en[0] = 1'b0;
    send(1'b0, 8'h55);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx",    {63'd0, tx_raw},       64'd1);
    chk("midrst_ready", {63'd0, if_raw.ready}, 64'd1);
    chk("midrst_busy",  {63'd0, busy_raw},     64'd0);
    rst_n = 1'b1;
    zeros = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_raw !== 1'b1) zeros++;
    end
    chk("midrst_line_idle", 64'(zeros), 64'd0);
    mon_en[0] = 1'b1;

    // ASCII 0x3F -> "3F\r\n"
    push_msg(1'b1, 8'h3F);
    send(1'b1, 8'h3F);
    lows = 0;
    for (int i = 0; i < 160; i++) begin
      if (if_asc.ready === 1'b0) lows++;
      @(negedge clk);
    end
    chk("asc_3f_ready_low",  64'(lows), 64'd160);
    chk("asc_3f_ready_back", {63'd0, if_asc.ready}, 64'd1);
    repeat (2) @(negedge clk);

    // back-to-back 0x09 then 0xA0 with valid held high
    push_msg(1'b1, 8'h09);
    push_msg(1'b1, 8'hA0);
    drive(1'b1, 8'h09, 1'b1);
    @(negedge clk);
    chk("b2b_first_accept", {63'd0, if_asc.ready}, 64'd0);
    drive(1'b1, 8'hA0, 1'b1);
    lows = 0;
    while (if_asc.ready === 1'b0 && lows < 400) begin
      lows++;
      @(negedge clk);
    end
    chk("b2b_first_len", 64'(lows), 64'd160);
    @(negedge clk);
    chk("b2b_second_accept", {63'd0, if_asc.ready}, 64'd0);
    drive(1'b1, 8'h00, 1'b0);
    wait_ready(1'b1, "b2b_done");
    repeat (2) @(negedge clk);

    // valid while busy is ignored
    push_msg(1'b1, 8'h12);
    send(1'b1, 8'h12);
    drive(1'b1, 8'hFF, 1'b1);
    repeat (20) @(negedge clk);
    drive(1'b1, 8'h00, 1'b0);
    wait_ready(1'b1, "busy_ign_done");
    repeat (5) @(negedge clk);
    chk("busy_ign_idle", {63'd0, busy_asc}, 64'd0);

    repeat (60) @(negedge clk);
    chk("raw_queue_empty", 64'(exp_raw.size()), 64'd0);
    chk("asc_queue_empty", 64'(exp_asc.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
